// File: rtl/ch_msg_loader.sv
// ch_msg_loader
// Packs a stream of quantised channel-LLR beats into full-width RAM pages and
// issues one single-cycle write per page until a whole codeword frame is
// stored. The loader owns the RAM write side for the entire load phase;
// frame_done_o marks the point after which the RAM contents are valid.
module ch_msg_loader #(
  parameter int QUAN_SIZE      = 4,
  parameter int CH_IN_NUM      = 45,
  parameter int BEATS_PER_PAGE = 17,
  parameter int PAGE_NUM       = 10,
  parameter int ADDR_WIDTH     = 8,
  parameter int BASE_ADDR      = 0,
  localparam int BEAT_WIDTH    = CH_IN_NUM * QUAN_SIZE,
  localparam int PAGE_WIDTH    = BEAT_WIDTH * BEATS_PER_PAGE
) (
  input  logic                  read_clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic                  llr_valid_i,
  input  logic [BEAT_WIDTH-1:0] llr_i,
  output logic                  llr_ready_o,
  output logic [PAGE_WIDTH-1:0] ram_din_o,
  output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
  output logic                  ram_we_o,
  output logic                  busy_o,
  output logic                  frame_done_o
);

  // A single-beat page still needs a one-bit counter so the port widths stay legal.
  localparam int BEAT_CNT_W = (BEATS_PER_PAGE > 1) ? $clog2(BEATS_PER_PAGE) : 1;

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_PAGE - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PAGE = ADDR_WIDTH'(PAGE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;
  logic [ADDR_WIDTH-1:0]   r_page_cnt;
  logic [PAGE_WIDTH-1:0]   r_page;

  logic                    w_accept;
  logic                    w_last_beat;
  logic                    w_last_page;

  // A beat is consumed only while filling; ready is a pure state decode, so
  // there is no combinational path from llr_valid_i back to llr_ready_o.
  assign w_accept    = (r_state == S_FILL) && llr_valid_i;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  assign w_last_page = (r_page_cnt == LAST_PAGE);

  // State register; a synchronous reset abandons any partial page without a write.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: start only matters in IDLE, the last beat closes a page,
  // the last page ends the frame.
  // NOTE: the next state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept && w_last_beat) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = w_last_page ? S_DONE : S_FILL;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the registered state; the address is forced to zero
  // outside WRITE so the RAM port is quiet whenever we is low.
  always_comb begin
    llr_ready_o      = 1'b0;
    ram_we_o         = 1'b0;
    busy_o           = 1'b0;
    frame_done_o     = 1'b0;
    ram_write_addr_o = '0;
    case (r_state)
      S_FILL: begin
        llr_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_WRITE: begin
        ram_we_o         = 1'b1;
        busy_o           = 1'b1;
        // Wraps modulo 2^ADDR_WIDTH by construction of the operand widths.
        ram_write_addr_o = BASE + r_page_cnt;
      end
      S_DONE: begin
        frame_done_o = 1'b1;
      end
      default: begin
        llr_ready_o = 1'b0;
      end
    endcase
  end

  // Beat and page counters: cleared on a fresh start, beat wraps at page end,
  // page advances when a non-final page has been written.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      r_beat_cnt <= '0;
      r_page_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_beat_cnt <= '0;
            r_page_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          if (!w_last_page) begin
            r_page_cnt <= r_page_cnt + 1'b1;
          end
        end
        default: begin
          r_beat_cnt <= r_beat_cnt;
        end
      endcase
    end
  end

  // Page register: each accepted beat lands in its own slot, beat 0 in the
  // least significant position. Slots are not cleared between pages because
  // every slot is rewritten before the next write.
  // NOTE: this wide storage register is reset on purpose so the RAM din bus
  // shows all-zero after reset; a RAM-style array would normally not be reset.
  always_ff @(posedge read_clk) begin
    if (!rstn) begin
      r_page <= '0;
    end else if (w_accept) begin
      r_page[int'(r_beat_cnt) * BEAT_WIDTH +: BEAT_WIDTH] <= llr_i;
    end
  end

  assign ram_din_o = r_page;

endmodule

// File: tb/tb_ch_msg_loader.sv
// Testbench for ch_msg_loader: two instances (PAGE_NUM=2 at base 0, PAGE_NUM=3
// at base 100). Stimulus pushes expected RAM writes / frame-done pulses into a
// per-instance queue; a negedge monitor pops and compares whenever the DUT
// presents a write or done pulse.
module tb_ch_msg_loader;

  localparam int QS  = 4;
  localparam int CN  = 45;
  localparam int BPP = 17;
  localparam int AW  = 8;
  localparam int BW  = QS * CN;
  localparam int PW  = BW * BPP;

  typedef struct {
    bit              is_done;
    int              addr;
    logic [PW-1:0]   data;
    int              cyc;     // expected cycle, -1 when not timed
  } exp_t;

  logic read_clk = 1'b0;
  logic rstn;
  int   cyc = 0;

  always #5 read_clk = ~read_clk;
  always @(posedge read_clk) cyc <= cyc + 1;

  logic          start_s [2];
  logic          vld_s   [2];
  logic [BW-1:0] llr_s   [2];
  logic          rdy_s   [2];
  logic          we_s    [2];
  logic          busy_s  [2];
  logic          done_s  [2];
  logic [AW-1:0] addr_s  [2];
  logic [PW-1:0] din_s   [2];

  ch_msg_loader #(
    .QUAN_SIZE(QS), .CH_IN_NUM(CN), .BEATS_PER_PAGE(BPP),
    .PAGE_NUM(2), .ADDR_WIDTH(AW), .BASE_ADDR(0)
  ) dut_a (
    .read_clk(read_clk), .rstn(rstn), .start_i(start_s[0]),
    .llr_valid_i(vld_s[0]), .llr_i(llr_s[0]), .llr_ready_o(rdy_s[0]),
    .ram_din_o(din_s[0]), .ram_write_addr_o(addr_s[0]), .ram_we_o(we_s[0]),
    .busy_o(busy_s[0]), .frame_done_o(done_s[0])
  );

  ch_msg_loader #(
    .QUAN_SIZE(QS), .CH_IN_NUM(CN), .BEATS_PER_PAGE(BPP),
    .PAGE_NUM(3), .ADDR_WIDTH(AW), .BASE_ADDR(100)
  ) dut_b (
    .read_clk(read_clk), .rstn(rstn), .start_i(start_s[1]),
    .llr_valid_i(vld_s[1]), .llr_i(llr_s[1]), .llr_ready_o(rdy_s[1]),
    .ram_din_o(din_s[1]), .ram_write_addr_o(addr_s[1]), .ram_we_o(we_s[1]),
    .busy_o(busy_s[1]), .frame_done_o(done_s[1])
  );

  int n_checks = 0;
  int n_fails  = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  bit       mon_en  = 1'b0;
  bit       cap_req = 1'b0;
  logic [3:0] cap_nib;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_page(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      for (int i = 0; i < PW / QS; i++) begin
        if (got[i*QS +: QS] !== exp[i*QS +: QS]) begin
          $display("FAIL %s: first differing LLR %0d (beat %0d) got %0h, expected %0h",
                   name, i, i / CN, got[i*QS +: QS], exp[i*QS +: QS]);
          break;
        end
      end
    end
  endtask

  // LLR j of beat b carries (b + j + off) mod 16.
  function automatic logic [BW-1:0] mk_beat(input int b, input int off);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < CN; j++) v[j*QS +: QS] = 4'((b + j + off) % 16);
    return v;
  endfunction

  function automatic logic [PW-1:0] mk_page(input int off);
    logic [PW-1:0] pg;
    pg = '0;
    for (int b = 0; b < BPP; b++)
      for (int j = 0; j < CN; j++)
        pg[(b*CN + j)*QS +: QS] = 4'((b + j + off) % 16);
    return pg;
  endfunction

  function automatic int base_of(input int k);
    return (k == 0) ? 0 : 100;
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    if (k == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic sb_pop(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{is_done: 1'b0, addr: 0, data: '0, cyc: -1};
    if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
    if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
  endtask

  // Monitor: any write or done pulse must match the head of the queue.
  // The interval after clock edge n is cycle n+1 in start-relative terms.
  task automatic monitor(input int k);
    exp_t e;
    bit   ok;
    if (we_s[k] === 1'b1 || done_s[k] === 1'b1) begin
      sb_pop(k, e, ok);
      if (!ok) begin
        n_checks++;
        n_fails++;
        $display("FAIL k%0d unexpected_event: we=%0b done=%0b addr=%0d, required no event",
                 k, we_s[k], done_s[k], addr_s[k]);
      end else if (we_s[k] === 1'b1) begin
        if (k == 0 && cap_req) begin
          cap_nib = din_s[k][183:180];
          cap_req = 1'b0;
        end
        check($sformatf("k%0d event_kind_write", k), 64'(e.is_done), 64'(0));
        check($sformatf("k%0d write_addr", k), 64'(addr_s[k]), 64'(e.addr));
        check_page($sformatf("k%0d write_data", k), din_s[k], e.data);
        check($sformatf("k%0d ready_in_write", k), 64'(rdy_s[k]), 64'(0));
        if (e.cyc >= 0) check($sformatf("k%0d write_cycle", k), 64'(cyc + 1), 64'(e.cyc));
      end else begin
        check($sformatf("k%0d event_kind_done", k), 64'(e.is_done), 64'(1));
        check($sformatf("k%0d busy_in_done", k), 64'(busy_s[k]), 64'(0));
        if (e.cyc >= 0) check($sformatf("k%0d done_cycle", k), 64'(cyc + 1), 64'(e.cyc));
      end
    end
  endtask

  always @(negedge read_clk) begin
    if (mon_en) begin
      for (int k = 0; k < 2; k++) monitor(k);
    end
  end

  task automatic check_quiet(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s k%0d ready", tag, k), 64'(rdy_s[k]), 64'(0));
      check($sformatf("%s k%0d we", tag, k), 64'(we_s[k]), 64'(0));
      check($sformatf("%s k%0d busy", tag, k), 64'(busy_s[k]), 64'(0));
      check($sformatf("%s k%0d done", tag, k), 64'(done_s[k]), 64'(0));
      check($sformatf("%s k%0d addr", tag, k), 64'(addr_s[k]), 64'(0));
      check_page($sformatf("%s k%0d din", tag, k), din_s[k], '0);
    end
  endtask

  // Drives one frame into instance k. max_beats < 0 sends the whole frame;
  // otherwise the stream stops after that many accepted beats and only the
  // pages that were completed are expected.
  task automatic run_frame(input int k, input int np, input int off, input bit gaps,
                           input int max_beats);
    int   total;
    int   t0;
    bit   ph;
    logic r;
    exp_t e;
    total = 0;
    ph    = 1'b1;
    start_s[k] = 1'b1;
    t0 = cyc + 1;
    @(posedge read_clk); #1;
    start_s[k] = 1'b0;
    for (int p = 0; p < np; p++) begin
      int o;
      int b;
      int guard;
      o = off + 5 * p;
      b = 0;
      guard = 0;
      if (max_beats < 0 || total + BPP <= max_beats) begin
        e = '{is_done: 1'b0, addr: base_of(k) + p, data: mk_page(o),
              cyc: gaps ? -1 : t0 + (BPP + 1) * (p + 1)};
        sb_push(k, e);
      end
      while (b < BPP) begin
        if (max_beats >= 0 && total >= max_beats) begin
          vld_s[k] = 1'b0;
          return;
        end
        vld_s[k] = gaps ? ph : 1'b1;
        llr_s[k] = mk_beat(b, o);
        @(negedge read_clk);
        r = rdy_s[k];
        @(posedge read_clk); #1;
        if (vld_s[k] && r) begin
          b++;
          total++;
        end
        ph = ~ph;
        guard++;
        if (guard > 4 * BPP + 8) begin
          n_checks++;
          n_fails++;
          $display("FAIL k%0d beat_accept_timeout: page %0d got %0d beats, required %0d",
                   k, p, b, BPP);
          vld_s[k] = 1'b0;
          return;
        end
      end
    end
    vld_s[k] = 1'b0;
    if (max_beats < 0) begin
      e = '{is_done: 1'b1, addr: 0, data: '0,
            cyc: gaps ? -1 : t0 + (BPP + 1) * np + 1};
      sb_push(k, e);
    end
  endtask

  task automatic wait_drain(input int k);
    int g;
    g = 0;
    while (sb_size(k) != 0 && g < 80) begin
      @(posedge read_clk); #1;
      g++;
    end
    n_checks++;
    if (sb_size(k) != 0) begin
      n_fails++;
      $display("FAIL k%0d drain_timeout: %0d events outstanding, required 0", k, sb_size(k));
      if (k == 0) sb0.delete();
      else        sb1.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      vld_s[k]   = 1'b0;
      llr_s[k]   = '0;
    end

    // Reset with random start/valid activity: everything must stay at zero.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 2; k++) begin
        start_s[k] = 1'($urandom);
        vld_s[k]   = 1'($urandom);
        llr_s[k]   = mk_beat(int'($urandom_range(0, 15)), i);
      end
      @(posedge read_clk); #1;
      check_quiet($sformatf("reset%0d", i));
    end
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0;
      vld_s[k]   = 1'b0;
    end
    rstn   = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge read_clk);
    #1;

    // Single frame, PAGE_NUM=2, continuous valid: writes at 18/36, done at 37.
    cap_req = 1'b1;
    run_frame(0, 2, 0, 1'b0, -1);
    wait_drain(0);
    check("first_page_beat1_llr0", 64'(cap_nib), 64'(1));

    // Valid toggling every cycle: identical page contents, untimed.
    run_frame(0, 2, 0, 1'b1, -1);
    wait_drain(0);

    // Base address 100, three pages: addresses 100..102 only.
    run_frame(1, 3, 3, 1'b0, -1);
    wait_drain(1);

    // start_i pulsed during FILL and in the DONE cycle must be ignored.
    fork
      run_frame(0, 2, 2, 1'b0, -1);
      begin
        int g;
        repeat (6) @(posedge read_clk);
        #1;
        start_s[0] = 1'b1;
        @(posedge read_clk); #1;
        start_s[0] = 1'b0;
        g = 0;
        do begin
          @(negedge read_clk);
          g++;
        end while (!(we_s[0] === 1'b1 && addr_s[0] == 8'd1) && g < 100);
        @(posedge read_clk); #1;
        start_s[0] = 1'b1;
        @(posedge read_clk); #1;
        start_s[0] = 1'b0;
      end
    join
    wait_drain(0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("no_restart_ready%0d", i), 64'(rdy_s[0]), 64'(0));
      check($sformatf("no_restart_busy%0d", i), 64'(busy_s[0]), 64'(0));
      @(posedge read_clk); #1;
    end

    // Reset after beat 9 of page 1: no write for the partial page.
    run_frame(0, 2, 9, 1'b0, BPP + 10);
    rstn = 1'b0;
    @(posedge read_clk); #1;
    check_quiet("midreset");
    rstn = 1'b1;
    repeat (3) @(posedge read_clk);
    #1;
    check("midreset_pending", 64'(sb_size(0)), 64'(0));

    // Fresh frame after the reset: page 0 at base with new data only.
    run_frame(0, 2, 11, 1'b0, -1);
    wait_drain(0);

    repeat (3) @(posedge read_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ch_msg_loader.md
# ch_msg_loader

Channel-message loader that sits directly upstream of the channel message RAM. It accepts a stream of quantised channel LLRs, CH_IN_NUM per beat, and packs BEATS_PER_PAGE beats into one full-width RAM page. It then issues a single-cycle write (we, write address, din) for each page, and counts pages until one codeword frame is stored. It owns the RAM write side for the whole load phase; decoding reads may start only after `frame_done_o`.

## Interface
- QUAN_SIZE, 4, bits per LLR
- CH_IN_NUM, 45, LLRs per input beat
- BEATS_PER_PAGE, 17, beats packed into one RAM page (page = 765 LLRs)
- PAGE_NUM, 10, pages per codeword frame; must be ≤ 2^ADDR_WIDTH-1 (top page reserved all-zero, never written)
- ADDR_WIDTH, 8, RAM address width
- BASE_ADDR, 0, address of first page of a frame
- BEAT_WIDTH, CH_IN_NUM*QUAN_SIZE, derived
- PAGE_WIDTH, BEAT_WIDTH*BEATS_PER_PAGE, derived (3060)

- read_clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start_i  in  1  one-cycle request to load a new frame
- llr_valid_i  in  1  beat valid
- llr_i  in  BEAT_WIDTH  beat payload, LLR j at bits [(j+1)*QUAN_SIZE-1 : j*QUAN_SIZE]
- llr_ready_o  out  1  loader accepts a beat this cycle
- ram_din_o  out  PAGE_WIDTH  packed page to RAM din_i
- ram_write_addr_o  out  ADDR_WIDTH  page address to RAM write_addr_i
- ram_we_o  out  1  RAM write enable, one cycle per page
- busy_o  out  1  frame load in progress
- frame_done_o  out  1  one-cycle pulse after last page written

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE: llr_ready_o=0, busy_o=0. start_i=1 → FILL; page_cnt←0, beat_cnt←0.
- FILL: llr_ready_o=1. On llr_valid_i&&llr_ready_o, beat number beat_cnt goes into page register bits [(beat_cnt+1)*BEAT_WIDTH-1 : beat_cnt*BEAT_WIDTH], and beat_cnt increments. Beat 0 is therefore the least significant. Accepting beat BEATS_PER_PAGE-1 → WRITE, beat_cnt←0.
- WRITE: ram_we_o=1, ram_write_addr_o=BASE_ADDR+page_cnt, ram_din_o=full packed page, llr_ready_o=0. Next state: DONE if page_cnt==PAGE_NUM-1, else FILL with page_cnt+1.
- DONE: frame_done_o=1 for this single cycle, busy_o=0 → IDLE.
- busy_o=1 in FILL and WRITE.
- start_i outside IDLE is ignored. llr_valid_i in IDLE/WRITE/DONE is not consumed; the beat stays pending upstream.
- ram_din_o is driven directly from the page register. It is not cleared between pages; stale upper beats are overwritten before the next write. It is only meaningful when ram_we_o=1.
- Counters: beat_cnt is $clog2(BEATS_PER_PAGE) bits; page_cnt is ADDR_WIDTH bits. The address add wraps modulo 2^ADDR_WIDTH. The configuration must keep BASE_ADDR+PAGE_NUM-1 < 2^ADDR_WIDTH-1.

## Timing
- Reset (rstn=0 at a read_clk edge):
  - state←IDLE.
  - llr_ready_o, ram_we_o, busy_o, frame_done_o, ram_write_addr_o ← 0.
  - page register and ram_din_o ← 0.
  - beat_cnt, page_cnt ← 0.
- Reset mid-frame discards any partial page; no write is issued for it.
- start_i at edge t → FILL at t+1; llr_ready_o=1 from t+1.
- Last beat of a page accepted at edge t → ram_we_o=1 during cycle t+1 (seen by RAM at edge t+2).
- llr_ready_o returns to 1 at t+2 unless the page was the last one.
- Throughput: BEATS_PER_PAGE beats per BEATS_PER_PAGE+1 cycles with a continuous valid stream. A frame takes PAGE_NUM*(BEATS_PER_PAGE+1) cycles after start.
- Last page written in cycle w → frame_done_o=1 in cycle w+1. start_i in that DONE cycle is ignored; IDLE is reached at w+2.
- All outputs are registered or decoded from the registered state only; no combinational path from llr_valid_i to llr_ready_o.

## Test plan
- Reset behaviour: rstn=0 for 3 cycles with random llr_valid_i/start_i → all outputs 0; no ram_we_o.
- Single frame, PAGE_NUM=2, continuous valid, LLR j of beat b = (b+j) mod 16:
  - ram_we_o pulses at cycles 18 and 36 after start, with addrs 0 and 1.
  - ram_din_o bits [183:180] = 1 (beat 1, LLR 0).
  - frame_done_o at cycle 37.
- Backpressure and gaps: llr_valid_i toggles 1/0 every cycle → exactly 17 accepted beats per page, page content identical to the continuous case, llr_ready_o=0 during each WRITE cycle.
- BASE_ADDR=100, PAGE_NUM=3 → writes at addrs 100, 101, 102 only; address 255 is never written.
- start_i during FILL and in the DONE cycle → no restart; page_cnt is unchanged and a single frame_done_o is seen.
- Reset asserted after beat 9 of page 1 → no write for page 1. A new start then loads page 0 at BASE_ADDR with fresh data and no leakage of the old beats.
